// File: rtl/sbox_share_ctrl.sv
`default_nettype none
// ============================================================================
// sbox_share_ctrl : four shared AES S-boxes arbitrated between a column-serial
// SubBytes requester and a key-schedule SubWord requester.
// Revision 1.0
// ============================================================================

module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 (maps 0 to 0), followed by the AES affine transform.
  function automatic logic [7:0] sub_byte(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign out_o = sub_byte(in_i);

endmodule

module sbox_share_ctrl #(
  parameter int COLS_PER_BEAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_ack,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_ack,
  output logic [31:0]  kw_out,
  output logic         kw_done,
  output logic         busy
);

  localparam int COL_W = 32 * COLS_PER_BEAT;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    W    = 3'd5
  } state_t;

  state_t       state_q;
  logic         last_kw_q;
  logic [127:0] st_buf_q;
  logic [127:0] st_out_q;
  logic [31:0]  kw_buf_q;
  logic [31:0]  kw_out_q;
  logic         st_ack_q;
  logic         st_done_q;
  logic         kw_ack_q;
  logic         kw_done_q;
  logic         busy_q;

  logic [COL_W-1:0] w_sbox_in;
  logic [COL_W-1:0] w_sbox_out;

  always_comb begin
    w_sbox_in = kw_buf_q;
    case (state_q)
      S0:      w_sbox_in = st_buf_q[127:96];
      S1:      w_sbox_in = st_buf_q[95:64];
      S2:      w_sbox_in = st_buf_q[63:32];
      S3:      w_sbox_in = st_buf_q[31:0];
      default: w_sbox_in = kw_buf_q;
    endcase
  end

  for (genvar i = 0; i < COL_W / 8; i++) begin : g_sbox
    sbox u_sbox (
      .in_i  (w_sbox_in[8*i +: 8]),
      .out_o (w_sbox_out[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_kw_q <= 1'b0;
      st_buf_q  <= '0;
      st_out_q  <= '0;
      kw_buf_q  <= '0;
      kw_out_q  <= '0;
      st_ack_q  <= 1'b0;
      st_done_q <= 1'b0;
      kw_ack_q  <= 1'b0;
      kw_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      st_ack_q  <= 1'b0;
      st_done_q <= 1'b0;
      kw_ack_q  <= 1'b0;
      kw_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // On a tie the requester that did not win last time goes first.
          if (st_req && (!kw_req || last_kw_q)) begin
            st_buf_q  <= st_in;
            st_ack_q  <= 1'b1;
            last_kw_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S0;
          end else if (kw_req) begin
            kw_buf_q  <= kw_in;
            kw_ack_q  <= 1'b1;
            last_kw_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= W;
          end
        end
        S0: begin
          st_out_q[127:96] <= w_sbox_out;
          state_q          <= S1;
        end
        S1: begin
          st_out_q[95:64] <= w_sbox_out;
          state_q         <= S2;
        end
        S2: begin
          st_out_q[63:32] <= w_sbox_out;
          state_q         <= S3;
        end
        S3: begin
          st_out_q[31:0] <= w_sbox_out;
          st_done_q      <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
        W: begin
          kw_out_q  <= w_sbox_out;
          kw_done_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign st_ack  = st_ack_q;
  assign st_out  = st_out_q;
  assign st_done = st_done_q;
  assign kw_ack  = kw_ack_q;
  assign kw_out  = kw_out_q;
  assign kw_done = kw_done_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox_share_ctrl.sv
`default_nettype none
// Bench for sbox_share_ctrl: scenario tasks plus randomized traffic checked
// against a table-driven S-box and spec-level latency/arbitration rules.
module tb_sbox_share_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         st_req = 1'b0;
  logic [127:0] st_in = '0;
  logic         kw_req = 1'b0;
  logic [31:0]  kw_in = '0;
  logic         st_ack, st_done, kw_ack, kw_done, busy;
  logic [127:0] st_out;
  logic [31:0]  kw_out;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0, base = 0;
  int st_ack_n, st_done_n, kw_ack_n, kw_done_n;
  int st_ack_at, st_done_at, kw_ack_at, kw_done_at;
  int clash_n = 0;
  logic prev_sa = 0, prev_sd = 0, prev_ka = 0, prev_kd = 0;
  logic st_drop = 1'b1, kw_drop = 1'b1;

  logic [127:0] exp_st = '0;
  logic [31:0]  exp_kw = '0;
  logic [7:0]   sb [0:255];

  always #5 clk = ~clk;

  sbox_share_ctrl #(.COLS_PER_BEAT(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .st_req  (st_req),
    .st_in   (st_in),
    .st_ack  (st_ack),
    .st_out  (st_out),
    .st_done (st_done),
    .kw_req  (kw_req),
    .kw_in   (kw_in),
    .kw_ack  (kw_ack),
    .kw_out  (kw_out),
    .kw_done (kw_done),
    .busy    (busy)
  );

  // S-box table built by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic mon_clear();
    base = cyc;
    st_ack_n = 0; st_done_n = 0; kw_ack_n = 0; kw_done_n = 0;
    st_ack_at = -1; st_done_at = -1; kw_ack_at = -1; kw_done_at = -1;
  endtask

  // One clock; samples 1 ns after the edge and lets requesters drop on ack.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (st_ack)  begin st_ack_n++;  st_ack_at  = cyc - base; if (st_drop) st_req = 1'b0; end
    if (kw_ack)  begin kw_ack_n++;  kw_ack_at  = cyc - base; if (kw_drop) kw_req = 1'b0; end
    if (st_done) begin st_done_n++; st_done_at = cyc - base; end
    if (kw_done) begin kw_done_n++; kw_done_at = cyc - base; end
    if ((st_ack || st_done) && (kw_ack || kw_done)) clash_n++;
    if ((st_ack && prev_sa) || (st_done && prev_sd) || (kw_ack && prev_ka) || (kw_done && prev_kd))
      clash_n++;
    prev_sa = st_ack; prev_sd = st_done; prev_ka = kw_ack; prev_kd = kw_done;
  endtask

  task automatic do_reset();
    st_req = 1'b0;
    kw_req = 1'b0;
    rst_n  = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
    exp_st = '0;
    exp_kw = '0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({st_ack, st_done, kw_ack, kw_done, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {st_ack, st_done, kw_ack, kw_done, busy});
    end
    n_tests++;
    if (st_out !== 128'h0 || kw_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got st_out=%h kw_out=%h expected zeros", st_out, kw_out);
    end
    do_reset();
    step();
    n_tests++;
    if (busy !== 1'b0 || st_out !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b st_out=%h expected 0/0", busy, st_out);
    end
  endtask

  task automatic test_state_vector();
    logic [127:0] vin, vexp, old;
    vin  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    vexp = 128'hd42711aee0bf98f1b8b45de51e415230;
    old  = exp_st;
    mon_clear();
    st_in  = vin;
    st_req = 1'b1;
    step();
    n_tests++;
    if (st_ack !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL st_ack_grant: got ack=%b busy=%b expected 1/1", st_ack, busy);
    end
    st_in = ~vin;
    step();
    n_tests++;
    if (st_out !== {vexp[127:96], old[95:0]}) begin
      n_fail++;
      $display("FAIL st_partial_col0: got %h expected %h", st_out, {vexp[127:96], old[95:0]});
    end
    for (int k = 3; k <= 12 && st_done_n == 0; k++) step();
    n_tests++;
    if (st_done_at !== 5) begin
      n_fail++;
      $display("FAIL st_done_latency: got %0d expected 5", st_done_at);
    end
    n_tests++;
    if (st_out !== vexp) begin
      n_fail++;
      $display("FAIL st_vector: got %h expected %h", st_out, vexp);
    end
    step();
    n_tests++;
    if (st_done !== 1'b0 || busy !== 1'b0 || st_ack_n !== 1) begin
      n_fail++;
      $display("FAIL st_pulse_width: got done=%b busy=%b acks=%0d expected 0/0/1", st_done, busy, st_ack_n);
    end
    exp_st = vexp;
  endtask

  task automatic test_word_vector();
    mon_clear();
    kw_in  = 32'hcf4f3c09;
    kw_req = 1'b1;
    for (int k = 1; k <= 8 && kw_done_n == 0; k++) step();
    n_tests++;
    if (kw_ack_at !== 1 || kw_done_at !== 2) begin
      n_fail++;
      $display("FAIL kw_latency: got ack@%0d done@%0d expected 1/2", kw_ack_at, kw_done_at);
    end
    n_tests++;
    if (kw_out !== 32'h8a84eb01 || st_out !== exp_st) begin
      n_fail++;
      $display("FAIL kw_vector: got kw=%h st=%h expected kw=8a84eb01 st=%h", kw_out, st_out, exp_st);
    end
    exp_kw = 32'h8a84eb01;
  endtask

  task automatic test_tie_round_robin();
    logic [127:0] a;
    logic [31:0]  c;
    do_reset();
    a = rand128();
    c = $urandom();
    mon_clear();
    st_in  = a;
    kw_in  = 32'hcf4f3c09;
    st_req = 1'b1;
    kw_req = 1'b1;
    step();
    n_tests++;
    if (kw_ack !== 1'b1 || st_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_first_kw: got kw_ack=%b st_ack=%b expected 1/0", kw_ack, st_ack);
    end
    step();
    n_tests++;
    if (kw_done !== 1'b1 || kw_out !== 32'h8a84eb01) begin
      n_fail++;
      $display("FAIL tie_kw_result: got done=%b kw=%h expected 1/8a84eb01", kw_done, kw_out);
    end
    kw_in  = c;
    kw_req = 1'b1;
    for (int k = 3; k <= 25 && kw_done_n < 2; k++) step();
    n_tests++;
    if (st_ack_at !== 3 || st_done_at !== 7 || kw_ack_at !== 8 || kw_done_at !== 9) begin
      n_fail++;
      $display("FAIL tie_second_order: got st %0d/%0d kw %0d/%0d expected st 3/7 kw 8/9",
               st_ack_at, st_done_at, kw_ack_at, kw_done_at);
    end
    n_tests++;
    if (st_out !== sub_state(a) || kw_out !== sub_word(c)) begin
      n_fail++;
      $display("FAIL tie_results: got st=%h kw=%h expected st=%h kw=%h", st_out, kw_out, sub_state(a), sub_word(c));
    end
    exp_st = sub_state(a);
    exp_kw = sub_word(c);
  endtask

  task automatic test_wait_while_busy();
    logic [127:0] d;
    logic [31:0]  f;
    logic [7:1]   bz;
    d  = rand128();
    f  = $urandom();
    bz = '0;
    mon_clear();
    st_in  = d;
    st_req = 1'b1;
    step(); bz[1] = busy;
    step(); bz[2] = busy;
    kw_in  = f;
    kw_req = 1'b1;
    for (int k = 3; k <= 7; k++) begin
      step();
      bz[k] = busy;
    end
    n_tests++;
    if (bz !== 7'b0101111) begin
      n_fail++;
      $display("FAIL wait_busy_profile: got %b expected 0101111", bz);
    end
    n_tests++;
    if (st_done_at !== 5 || kw_ack_at !== 6 || kw_done_at !== 7 || kw_out !== sub_word(f)) begin
      n_fail++;
      $display("FAIL wait_kw_grant: got st_done@%0d kw %0d/%0d kw_out=%h expected 5, 6/7, %h",
               st_done_at, kw_ack_at, kw_done_at, kw_out, sub_word(f));
    end
    exp_st = sub_state(d);
    exp_kw = sub_word(f);
  endtask

  task automatic test_reset_mid_op();
    mon_clear();
    st_in  = rand128();
    st_req = 1'b1;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (st_out !== 128'h0 || kw_out !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got st=%h kw=%h busy=%b expected zeros", st_out, kw_out, busy);
    end
    step(); step();
    rst_n  = 1'b1;
    exp_st = '0;
    exp_kw = '0;
    for (int k = 0; k < 8; k++) step();
    n_tests++;
    if (st_done_n !== 0 || busy !== 1'b0 || st_out !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_mid_no_resume: got dones=%0d busy=%b st=%h expected 0/0/0", st_done_n, busy, st_out);
    end
    mon_clear();
    st_in  = '0;
    st_req = 1'b1;
    for (int k = 1; k <= 12 && st_done_n == 0; k++) step();
    n_tests++;
    if (st_out !== {16{8'h63}} || st_done_at !== 5) begin
      n_fail++;
      $display("FAIL reset_mid_zero_state: got %h @%0d expected %h @5", st_out, st_done_at, {16{8'h63}});
    end
    exp_st = {16{8'h63}};
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, first_out;
    a         = rand128();
    first_out = '0;
    st_drop   = 1'b0;
    mon_clear();
    st_in  = a;
    st_req = 1'b1;
    step();
    st_in = {16{8'hff}};
    for (int k = 2; k <= 25 && st_done_n < 2; k++) begin
      step();
      if (st_ack_n == 2) st_req = 1'b0;
      if (st_done && st_done_n == 1) first_out = st_out;
    end
    st_drop = 1'b1;
    n_tests++;
    if (first_out !== sub_state(a)) begin
      n_fail++;
      $display("FAIL b2b_first: got %h expected %h", first_out, sub_state(a));
    end
    n_tests++;
    if (st_out !== {16{8'h16}} || st_ack_at !== 6 || st_done_at !== 10) begin
      n_fail++;
      $display("FAIL b2b_second: got %h ack@%0d done@%0d expected %h ack@6 done@10",
               st_out, st_ack_at, st_done_at, {16{8'h16}});
    end
    exp_st = {16{8'h16}};
  endtask

  // Random traffic; arbitration expectation comes from a round-robin flag.
  task automatic test_random();
    logic [127:0] a;
    logic [31:0]  b;
    logic         m_last_kw;
    int           sel, e_sa, e_sd, e_ka, e_kd;
    do_reset();
    m_last_kw = 1'b0;
    for (int it = 0; it < 40; it++) begin
      a   = rand128();
      b   = $urandom();
      sel = $urandom_range(1, 3);
      e_sa = -1; e_sd = -1; e_ka = -1; e_kd = -1;
      if (sel == 1) begin
        e_sa = 1; e_sd = 5; m_last_kw = 1'b0;
      end else if (sel == 2) begin
        e_ka = 1; e_kd = 2; m_last_kw = 1'b1;
      end else if (m_last_kw) begin
        e_sa = 1; e_sd = 5; e_ka = 6; e_kd = 7; m_last_kw = 1'b1;
      end else begin
        e_ka = 1; e_kd = 2; e_sa = 3; e_sd = 7; m_last_kw = 1'b0;
      end
      if (sel != 2) exp_st = sub_state(a);
      if (sel != 1) exp_kw = sub_word(b);
      mon_clear();
      st_in  = a;
      kw_in  = b;
      st_req = (sel != 2);
      kw_req = (sel != 1);
      for (int k = 1; k <= 20 && !((sel == 2 || st_done_n > 0) && (sel == 1 || kw_done_n > 0)); k++)
        step();
      st_in = rand128();
      kw_in = $urandom();
      step();
      n_tests++;
      if (st_ack_at !== e_sa || st_done_at !== e_sd || kw_ack_at !== e_ka || kw_done_at !== e_kd) begin
        n_fail++;
        $display("FAIL rand_timing it=%0d sel=%0d: got st %0d/%0d kw %0d/%0d expected st %0d/%0d kw %0d/%0d",
                 it, sel, st_ack_at, st_done_at, kw_ack_at, kw_done_at, e_sa, e_sd, e_ka, e_kd);
      end
      n_tests++;
      if (st_out !== exp_st || kw_out !== exp_kw) begin
        n_fail++;
        $display("FAIL rand_data it=%0d: got st=%h kw=%h expected st=%h kw=%h", it, st_out, kw_out, exp_st, exp_kw);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
    n_tests++;
    if (clash_n !== 0) begin
      n_fail++;
      $display("FAIL pulse_rules: got %0d violations expected 0", clash_n);
    end
  endtask

  initial begin
    build_sbox();
    mon_clear();
    test_reset();
    test_state_vector();
    test_word_vector();
    test_tie_round_robin();
    test_wait_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
